// File: rtl/identify_pkg.sv
// Shared constants and the prefix-tracking state type for the identify pipe.
package identify_pkg;

  // Primary opcodes (word bits 0:5)
  localparam logic [5:0] OPC_PREFIX = 6'd1;
  localparam logic [5:0] OPC_BC     = 6'd16;
  localparam logic [5:0] OPC_B      = 6'd18;
  localparam logic [5:0] OPC_XL     = 6'd19;

  // Extended opcodes for primary opcode 19 (word bits 21:30)
  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;
  localparam logic [9:0] XO_BCTAR = 10'd560;

  typedef enum logic {
    PFX_IDLE = 1'b0,
    PFX_PEND = 1'b1
  } pfx_state_e;

endpackage

// File: rtl/identify_lane_dec.sv
// Single-lane branch/prefix decoder: one 32-bit word (big-endian bit order)
// to raw form bits and the prefix bit. Suffix handling lives in the top.
// bctar decoding is enabled by defining IDENTIFY_PIPE_TAR_EN.
module identify_lane_dec
  import identify_pkg::*;
(
  input  logic [0:31] word,
  output logic        i_form,
  output logic        b_form,
  output logic        cond_lr,
  output logic        cond_ctr,
  output logic        cond_tar,
  output logic        prefix
);

  logic [5:0] opcode;
  logic [9:0] xo;
  logic       unused_bits;

  assign opcode      = word[0:5];
  assign xo          = word[21:30];
  assign unused_bits = ^{word[6:20], word[31]};

  // Opcode/XO match for each form
  always_comb begin
    i_form   = (opcode == OPC_B);
    b_form   = (opcode == OPC_BC);
    cond_lr  = (opcode == OPC_XL) && (xo == XO_BCLR);
    cond_ctr = (opcode == OPC_XL) && (xo == XO_BCCTR);
`ifdef IDENTIFY_PIPE_TAR_EN
    cond_tar = (opcode == OPC_XL) && (xo == XO_BCTAR);
`else
    cond_tar = 1'b0;
`endif
    prefix   = (opcode == OPC_PREFIX);
  end

endmodule

// File: rtl/identify_pipe.sv
// One-cycle registered branch-identify stage with valid/ready handshake and
// prefix/suffix tracking across lanes and beats.
// Optional bctar decode: define IDENTIFY_PIPE_TAR_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// PFX_IDLE | no prefix outstanding; lane 0 of next beat decodes normally
// PFX_PEND | last accepted lane was a prefix; next beat's lane 0 is suffix
module identify_pipe
  import identify_pkg::*;
#(
  parameter int LANES = 2
)
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [0:32*LANES-1]  i_instr,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [0:32*LANES-1]  o_instr,
  output logic [0:LANES-1]     o_bru_en,
  output logic [0:LANES-1]     o_bru_i_form,
  output logic [0:LANES-1]     o_bru_b_form,
  output logic [0:LANES-1]     o_bru_cond_LR,
  output logic [0:LANES-1]     o_bru_cond_CTR,
  output logic [0:LANES-1]     o_bru_cond_TAR,
  output logic [0:LANES-1]     o_prefix,
  output logic [0:LANES-1]     o_suffix,
  output logic                 o_err
);

  pfx_state_e state_q, state_d;

  logic [0:LANES-1] raw_i, raw_b, raw_lr, raw_ctr, raw_tar, raw_pfx;
  logic [0:LANES-1] d_i, d_b, d_lr, d_ctr, d_tar, d_pfx, d_sfx, d_en;
  logic             d_err;
  logic             accept;

  // A flush discards whatever is held, so the block can always take the
  // cycle; the beat itself is still dropped.
  assign o_ready = !o_valid || i_ready || i_flush;
  assign accept  = i_valid && o_ready && !i_flush;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    identify_lane_dec u_dec (
      .word     (i_instr[32*g +: 32]),
      .i_form   (raw_i[g]),
      .b_form   (raw_b[g]),
      .cond_lr  (raw_lr[g]),
      .cond_ctr (raw_ctr[g]),
      .cond_tar (raw_tar[g]),
      .prefix   (raw_pfx[g])
    );
  end

  // Walk lanes in order: a lane after a prefix is a suffix unless it is itself
  // a prefix, in which case it stays a prefix and raises the error flag.
  always_comb begin
    logic prev_pfx;
    d_i      = '0;
    d_b      = '0;
    d_lr     = '0;
    d_ctr    = '0;
    d_tar    = '0;
    d_pfx    = '0;
    d_sfx    = '0;
    d_err    = 1'b0;
    prev_pfx = (state_q == PFX_PEND);
    for (int l = 0; l < LANES; l++) begin
      d_sfx[l] = prev_pfx && !raw_pfx[l];
      if (prev_pfx && raw_pfx[l]) d_err = 1'b1;
      d_pfx[l] = raw_pfx[l];
      d_i[l]   = raw_i[l]   && !d_sfx[l];
      d_b[l]   = raw_b[l]   && !d_sfx[l];
      d_lr[l]  = raw_lr[l]  && !d_sfx[l];
      d_ctr[l] = raw_ctr[l] && !d_sfx[l];
      d_tar[l] = raw_tar[l] && !d_sfx[l];
      prev_pfx = raw_pfx[l];
    end
    d_en = d_i | d_b | d_lr | d_ctr | d_tar;
  end

  // Prefix-pending next state
  always_comb begin
    state_d = state_q;
    if (i_flush)
      state_d = PFX_IDLE;
    else if (accept)
      state_d = raw_pfx[LANES-1] ? PFX_PEND : PFX_IDLE;
  end

  // Prefix-pending state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= PFX_IDLE;
    else       state_q <= state_d;
  end

  // Output register: load on accept, hold under backpressure, drain otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_err          <= 1'b0;
      o_instr        <= '0;
      o_bru_en       <= '0;
      o_bru_i_form   <= '0;
      o_bru_b_form   <= '0;
      o_bru_cond_LR  <= '0;
      o_bru_cond_CTR <= '0;
      o_bru_cond_TAR <= '0;
      o_prefix       <= '0;
      o_suffix       <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else if (accept) begin
      o_valid        <= 1'b1;
      o_err          <= d_err;
      o_instr        <= i_instr;
      o_bru_en       <= d_en;
      o_bru_i_form   <= d_i;
      o_bru_b_form   <= d_b;
      o_bru_cond_LR  <= d_lr;
      o_bru_cond_CTR <= d_ctr;
      o_bru_cond_TAR <= d_tar;
      o_prefix       <= d_pfx;
      o_suffix       <= d_sfx;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_identify_pipe.sv
// Directed bench for identify_pipe with LANES=2.
module tb_identify_pipe;

  localparam int LANES = 2;

  logic              i_clk = 1'b0;
  logic              i_rst, i_flush, i_valid, i_ready;
  logic [0:63]       i_instr;
  logic              o_ready, o_valid, o_err;
  logic [0:63]       o_instr;
  logic [0:1]        o_bru_en, o_bru_i_form, o_bru_b_form;
  logic [0:1]        o_bru_cond_LR, o_bru_cond_CTR, o_bru_cond_TAR;
  logic [0:1]        o_prefix, o_suffix;

  int vectors = 0;
  int errors  = 0;

  always #5 i_clk = ~i_clk;

  identify_pipe #(.LANES(LANES)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_instr        (i_instr),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_instr        (o_instr),
    .o_bru_en       (o_bru_en),
    .o_bru_i_form   (o_bru_i_form),
    .o_bru_b_form   (o_bru_b_form),
    .o_bru_cond_LR  (o_bru_cond_LR),
    .o_bru_cond_CTR (o_bru_cond_CTR),
    .o_bru_cond_TAR (o_bru_cond_TAR),
    .o_prefix       (o_prefix),
    .o_suffix       (o_suffix),
    .o_err          (o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_lanes(input string tag, input logic [1:0] en, input logic [1:0] pfx,
                           input logic [1:0] sfx, input logic err);
    chk({tag, ".valid"},  {63'd0, o_valid}, 64'd1);
    chk({tag, ".bru_en"}, {62'd0, o_bru_en}, {62'd0, en});
    chk({tag, ".prefix"}, {62'd0, o_prefix}, {62'd0, pfx});
    chk({tag, ".suffix"}, {62'd0, o_suffix}, {62'd0, sfx});
    chk({tag, ".err"},    {63'd0, o_err}, {63'd0, err});
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_instr = '0;
    step();
    step();
    i_rst = 1'b0;
    chk("rst.valid",  {63'd0, o_valid}, 64'd0);
    chk("rst.err",    {63'd0, o_err}, 64'd0);
    chk("rst.instr",  o_instr, 64'd0);
    chk("rst.bru_en", {62'd0, o_bru_en}, 64'd0);
    chk("rst.ready",  {63'd0, o_ready}, 64'd1);

    // b / bc
    i_valid = 1'b1; i_instr = {32'h48032BFB, 32'h41820008};
    step();
    chk_lanes("ib", 2'b11, 2'b00, 2'b00, 1'b0);
    chk("ib.i_form", {62'd0, o_bru_i_form}, 64'd2);
    chk("ib.b_form", {62'd0, o_bru_b_form}, 64'd1);
    chk("ib.instr",  o_instr, {32'h48032BFB, 32'h41820008});

    // bclr / bcctr
    i_instr = {32'h4E800020, 32'h4E800420};
    step();
    chk_lanes("lrctr", 2'b11, 2'b00, 2'b00, 1'b0);
    chk("lrctr.lr",  {62'd0, o_bru_cond_LR}, 64'd2);
    chk("lrctr.ctr", {62'd0, o_bru_cond_CTR}, 64'd1);

    // bctar
    i_instr = {32'h4E800460, 32'h00000000};
    step();
`ifdef IDENTIFY_PIPE_TAR_EN
    chk_lanes("tar", 2'b10, 2'b00, 2'b00, 1'b0);
    chk("tar.tar", {62'd0, o_bru_cond_TAR}, 64'd2);
`else
    chk_lanes("tar", 2'b00, 2'b00, 2'b00, 1'b0);
    chk("tar.tar", {62'd0, o_bru_cond_TAR}, 64'd0);
`endif

    // prefix + suffix inside one beat
    i_instr = {32'h04000000, 32'h48000000};
    step();
    chk_lanes("pfx_in", 2'b00, 2'b10, 2'b01, 1'b0);

    // prefix in last lane, suffix in next beat's lane 0
    i_instr = {32'h00000000, 32'h04000000};
    step();
    chk_lanes("pfx_last", 2'b00, 2'b01, 2'b00, 1'b0);
    i_instr = {32'h48000000, 32'h48000000};
    step();
    chk_lanes("sfx_next", 2'b01, 2'b00, 2'b10, 1'b0);
    chk("sfx_next.i_form", {62'd0, o_bru_i_form}, 64'd1);

    // prefix followed by prefix -> error, leaves PEND
    i_instr = {32'h04000000, 32'h04000000};
    step();
    chk_lanes("pfx_pfx", 2'b00, 2'b11, 2'b00, 1'b1);

    // flush in PEND drops beat and returns to IDLE
    i_flush = 1'b1; i_instr = {32'h48000000, 32'h48000000};
    #1;
    chk("flush.ready", {63'd0, o_ready}, 64'd1);
    step();
    i_flush = 1'b0;
    chk("flush.valid", {63'd0, o_valid}, 64'd0);
    i_instr = {32'h48000000, 32'h00000000};
    step();
    chk_lanes("post_flush", 2'b10, 2'b00, 2'b00, 1'b0);
    chk("post_flush.instr", o_instr, {32'h48000000, 32'h00000000});

    // backpressure: hold for 3 cycles, then stream 1 per cycle
    i_instr = {32'h48000004, 32'h00000000};
    step();
    chk("bp.x1", o_instr, {32'h48000004, 32'h00000000});
    i_ready = 1'b0; i_instr = {32'h48000008, 32'h00000000};
    #1;
    chk("bp.ready0", {63'd0, o_ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp.hold_instr", o_instr, {32'h48000004, 32'h00000000});
      chk("bp.hold_valid", {63'd0, o_valid}, 64'd1);
      chk("bp.hold_ready", {63'd0, o_ready}, 64'd0);
    end
    i_ready = 1'b1;
    #1;
    chk("bp.release_ready", {63'd0, o_ready}, 64'd1);
    step();
    chk("bp.x2", o_instr, {32'h48000008, 32'h00000000});
    i_instr = {32'h4800000C, 32'h00000000};
    step();
    chk("bp.x3", o_instr, {32'h4800000C, 32'h00000000});
    i_instr = {32'h48000010, 32'h41820008};
    step();
    chk("bp.x4", o_instr, {32'h48000010, 32'h41820008});
    chk_lanes("bp.x4", 2'b11, 2'b00, 2'b00, 1'b0);
    i_valid = 1'b0;
    step();
    chk("drain.valid", {63'd0, o_valid}, 64'd0);

    // reset mid-stream discards PEND and the held beat
    i_valid = 1'b1; i_instr = {32'h00000000, 32'h04000000};
    step();
    chk_lanes("pend2", 2'b00, 2'b01, 2'b00, 1'b0);
    i_rst = 1'b1; i_ready = 1'b0; i_instr = {32'h48000000, 32'h48000000};
    step();
    i_rst = 1'b0; i_ready = 1'b1;
    chk("mrst.valid",  {63'd0, o_valid}, 64'd0);
    chk("mrst.instr",  o_instr, 64'd0);
    chk("mrst.prefix", {62'd0, o_prefix}, 64'd0);
    chk("mrst.bru_en", {62'd0, o_bru_en}, 64'd0);
    i_instr = {32'h48000000, 32'h00000000};
    step();
    chk_lanes("post_rst", 2'b10, 2'b00, 2'b00, 1'b0);
    i_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
